// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 keyboard deserializer.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_st_t;

   localparam logic [7:0] PFX_EXT    = 8'hE0;
   localparam logic [7:0] PFX_BRK    = 8'hF0;
   localparam logic [7:0] PFX_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam logic [7:0] RPL_ACK    = 8'hFA;
   localparam logic [7:0] RPL_BAT    = 8'hAA;
   localparam logic [7:0] RPL_ECHO   = 8'hEE;
   localparam logic [7:0] RPL_RESEND = 8'hFE;
   localparam logic [7:0] RPL_OVR0   = 8'h00;
   localparam logic [7:0] RPL_OVR1   = 8'hFF;

   // Keyboard replies and overrun markers never reach the key decoder.
   function automatic logic is_reply(input logic [7:0] b);
      return (b == RPL_ACK)  || (b == RPL_BAT)    ||
             (b == RPL_ECHO) || (b == RPL_RESEND) ||
             (b == RPL_OVR0) || (b == RPL_OVR1);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one raw PS/2 line.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic line,
   output logic filt,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync <= 2'b11;
         cnt  <= '0;
         filt <= 1'b1;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], line};
         fall <= 1'b0;
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            // New level held long enough; fall fires only on 1->0.
            filt <= sync[1];
            fall <= filt;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard deserializer producing the 11-bit ps2_key event word.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated makes of the held key.
module ps2_key_gen
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 48000000,
   parameter int TIMEOUT_US = 200,
   parameter int FILTER_LEN = 8
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_stb,
   output logic        frame_err
);

   localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int TW     = $clog2(TO_CYC + 1);

   logic clk_lvl;
   logic clk_fall;
   logic dat;
   logic dat_fall;
   logic unused_ok;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .line    (ps2_clk),
      .filt    (clk_lvl),
      .fall    (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .line    (ps2_data),
      .filt    (dat),
      .fall    (dat_fall)
   );

   assign unused_ok = &{1'b0, clk_lvl, dat_fall};

   frame_st_t     st;
   logic [7:0]    shreg;
   logic [2:0]    bitcnt;
   logic          par;
   logic [TW-1:0] tcnt;
   logic          byte_ok;
   logic [7:0]    byte_r;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st        <= IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         par       <= 1'b0;
         tcnt      <= '0;
         byte_ok   <= 1'b0;
         byte_r    <= '0;
         frame_err <= 1'b0;
      end else begin
         byte_ok   <= 1'b0;
         frame_err <= 1'b0;
         if (clk_fall) begin
            tcnt <= '0;
            unique case (st)
               IDLE: begin
                  if (!dat) begin
                     st     <= DATA;
                     bitcnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg  <= {dat, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) st <= PARITY;
               end
               PARITY: begin
                  par <= dat;
                  st  <= STOP;
               end
               STOP: begin
                  st <= IDLE;
                  if (dat && (^{shreg, par})) begin
                     byte_ok <= 1'b1;
                     byte_r  <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end else if (st != IDLE) begin
            // Stalled mid-frame: drop the partial byte.
            if (tcnt == TW'(TO_CYC - 1)) begin
               st        <= IDLE;
               tcnt      <= '0;
               frame_err <= 1'b1;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
         end
      end
   end

   logic       ext;
   logic       brk;
   logic [2:0] skip;
`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [8:0] last_make;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ps2_key   <= '0;
         key_stb   <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         skip      <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         last_make <= '0;
`endif
      end else begin
         key_stb <= 1'b0;
         if (frame_err) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
         end else if (byte_ok) begin
            if (skip != 3'd0) begin
               skip <= skip - 3'd1;
            end else begin
               unique case (1'b1)
                  (byte_r == PFX_EXT):   ext  <= 1'b1;
                  (byte_r == PFX_BRK):   brk  <= 1'b1;
                  (byte_r == PFX_PAUSE): skip <= PAUSE_SKIP;
                  is_reply(byte_r):      ;
                  default: begin
                     ext <= 1'b0;
                     brk <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                     if (brk || ({ext, byte_r} != last_make)) begin
                        ps2_key <= {~ps2_key[10], ~brk, ext, byte_r};
                        key_stb <= 1'b1;
                     end
                     if (!brk)
                        last_make <= {ext, byte_r};
                     else if ({ext, byte_r} == last_make)
                        last_make <= '0;
`else
                     ps2_key <= {~ps2_key[10], ~brk, ext, byte_r};
                     key_stb <= 1'b1;
`endif
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: byte table plus timeout/glitch/pause/reset cases.
module tb_ps2_key_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        key_stb;
   logic        frame_err;

   int total = 0;
   int bad = 0;
   int stb_cnt = 0;
   int err_cnt = 0;

   // 1 MHz system clock: one cycle per microsecond, 200-cycle timeout.
   ps2_key_gen #(
      .CLK_HZ     (1000000),
      .TIMEOUT_US (200),
      .FILTER_LEN (8)
   ) dut (
      .clk_sys   (clk),
      .reset_n   (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .key_stb   (key_stb),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_stb) stb_cnt++;
      if (frame_err) err_cnt++;
   end

   typedef struct {
      logic [7:0]  code;
      bit          badp;
      int          stb;
      int          err;
      logic [10:0] key;
   } vec_t;

   vec_t tbl[18];
   logic [10:0] exp_key;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // 80-cycle bit period (12.5 kHz at 1 MHz); data set mid-high phase.
   task automatic send_frame(input logic [7:0] b, input bit badp,
                             input int nbits, input bit glitch,
                             input int gap_bit, input int gap_len);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ badp, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_cyc(20);
         if (glitch) begin
            ps2_clk = 1'b0;
            wait_cyc(1);
            ps2_clk = 1'b1;
         end
         ps2_clk = 1'b0;
         wait_cyc(20);
         if (glitch) begin
            ps2_clk = 1'b1;
            wait_cyc(1);
            ps2_clk = 1'b0;
         end
         wait_cyc(20);
         ps2_clk = 1'b1;
         wait_cyc(20 + ((i == gap_bit) ? gap_len : 0));
      end
      ps2_data = 1'b1;
   endtask

   task automatic frame_chk(input string nm, input logic [7:0] b,
                            input bit badp, input bit glitch,
                            input int gap_bit, input int gap_len,
                            input int e_stb, input int e_err,
                            input logic [10:0] e_key);
      int s0;
      int e0;
      s0 = stb_cnt;
      e0 = err_cnt;
      send_frame(b, badp, 11, glitch, gap_bit, gap_len);
      wait_cyc(60);
      chk({nm, "_stb"}, 32'(stb_cnt - s0), 32'(e_stb));
      chk({nm, "_err"}, 32'(err_cnt - e0), 32'(e_err));
      chk({nm, "_key"}, 32'(ps2_key), 32'(e_key));
   endtask

   function automatic logic [10:0] make_key(input logic [10:0] prev,
                                            input logic [7:0] code);
      return {~prev[10], 1'b1, 1'b0, code};
   endfunction

   function automatic vec_t mk(input logic [7:0] c, input bit bp,
                               input int s, input int e,
                               input logic [10:0] k);
      vec_t v;
      v.code = c;
      v.badp = bp;
      v.stb  = s;
      v.err  = e;
      v.key  = k;
      return v;
   endfunction

   initial begin
      int s0;
      int e0;
      logic [7:0] pause_seq [8];

      tbl[0]  = mk(8'h1C, 0, 1, 0, 11'h61C);
      tbl[1]  = mk(8'hF0, 0, 0, 0, 11'h61C);
      tbl[2]  = mk(8'h1C, 0, 1, 0, 11'h01C);
      tbl[3]  = mk(8'hE0, 0, 0, 0, 11'h01C);
      tbl[4]  = mk(8'h75, 0, 1, 0, 11'h775);
      tbl[5]  = mk(8'hE0, 0, 0, 0, 11'h775);
      tbl[6]  = mk(8'hF0, 0, 0, 0, 11'h775);
      tbl[7]  = mk(8'h75, 0, 1, 0, 11'h175);
      tbl[8]  = mk(8'h29, 1, 0, 1, 11'h175);
      tbl[9]  = mk(8'h29, 0, 1, 0, 11'h629);
      tbl[10] = mk(8'h1C, 0, 1, 0, 11'h21C);
`ifdef PS2_TYPEMATIC_FILTER_EN
      tbl[11] = mk(8'h1C, 0, 0, 0, 11'h21C);
      tbl[12] = mk(8'h1C, 0, 0, 0, 11'h21C);
`else
      tbl[11] = mk(8'h1C, 0, 1, 0, 11'h61C);
      tbl[12] = mk(8'h1C, 0, 1, 0, 11'h21C);
`endif
      tbl[13] = mk(8'hFA, 0, 0, 0, 11'h21C);
      tbl[14] = mk(8'hAA, 0, 0, 0, 11'h21C);
      tbl[15] = mk(8'hE0, 0, 0, 0, 11'h21C);
      tbl[16] = mk(8'h6B, 1, 0, 1, 11'h21C);
      tbl[17] = mk(8'h6B, 0, 1, 0, 11'h66B);

      pause_seq[0] = 8'hE1;
      pause_seq[1] = 8'h14;
      pause_seq[2] = 8'h77;
      pause_seq[3] = 8'hE1;
      pause_seq[4] = 8'hF0;
      pause_seq[5] = 8'h14;
      pause_seq[6] = 8'hF0;
      pause_seq[7] = 8'h77;

      wait_cyc(5);
      chk("rst_key", 32'(ps2_key), 32'h0);
      chk("rst_stb", 32'(key_stb), 32'h0);
      chk("rst_err", 32'(frame_err), 32'h0);
      rst_n = 1'b1;
      wait_cyc(30);

      for (int i = 0; i < 18; i++) begin
         frame_chk($sformatf("vec%0d", i), tbl[i].code, tbl[i].badp,
                   0, -1, 0, tbl[i].stb, tbl[i].err, tbl[i].key);
      end
      exp_key = 11'h66B;

      // Stall after start + 3 data bits.
      s0 = stb_cnt;
      e0 = err_cnt;
      send_frame(8'h55, 0, 4, 0, -1, 0);
      wait_cyc(300);
      chk("tmo_err", 32'(err_cnt - e0), 32'd1);
      chk("tmo_stb", 32'(stb_cnt - s0), 32'd0);
      exp_key = make_key(exp_key, 8'h32);
      frame_chk("post_tmo", 8'h32, 0, 0, -1, 0, 1, 0, exp_key);

      // 180-cycle gap between falls is still inside the timeout.
      exp_key = make_key(exp_key, 8'h4D);
      frame_chk("long_gap", 8'h4D, 0, 0, 9, 100, 1, 0, exp_key);

      exp_key = make_key(exp_key, 8'h1B);
      frame_chk("glitch", 8'h1B, 0, 1, -1, 0, 1, 0, exp_key);

      s0 = stb_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 8; i++) begin
         send_frame(pause_seq[i], 0, 11, 0, -1, 0);
         wait_cyc(40);
      end
      wait_cyc(20);
      chk("pause_stb", 32'(stb_cnt - s0), 32'd0);
      chk("pause_err", 32'(err_cnt - e0), 32'd0);
      chk("pause_key", 32'(ps2_key), 32'(exp_key));
      exp_key = make_key(exp_key, 8'h16);
      frame_chk("post_pause", 8'h16, 0, 0, -1, 0, 1, 0, exp_key);

      // Reset while the FSM sits in DATA.
      send_frame(8'h1C, 0, 4, 0, -1, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_key", 32'(ps2_key), 32'h0);
      chk("mid_rst_stb", 32'(key_stb), 32'h0);
      chk("mid_rst_err", 32'(frame_err), 32'h0);
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(30);
      exp_key = make_key(11'h000, 8'h1C);
      frame_chk("post_rst", 8'h1C, 0, 0, -1, 0, 1, 0, exp_key);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
